// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg -- shared constants and types for the instruction-fetch stage.
//   ADDR_BUS / INST_BUS : default address and instruction widths
//   ZERO_WORD           : all-zero word used for cleared registers
//   RST_ENABLE          : level of rst that means "in reset"
//   RESET_PC_DEF        : first fetch address after reset
//   NOP_INST            : instruction value presented to ID when nothing valid
//   if_state_e          : fetch FSM state encoding
package if_fetch_pkg;

  localparam int          ADDR_BUS     = 32;
  localparam int          INST_BUS     = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_pc_next.sv
// if_pc_next -- next fetch address selection.
//   fetch_pc    in  : address of the word currently being fetched/held
//   branch_flag in  : ID holds a taken jump/branch
//   branch_addr in  : jump/branch target from ID
//   next_pc     out : branch target, else fetch_pc + 4 (wraps modulo 2^ADDR_W)
module if_pc_next
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS
) (
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] next_pc
);

  assign next_pc = branch_flag ? branch_addr : fetch_pc + ADDR_W'(4);

endmodule

// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage and IF/ID pipeline register.
//   clk, rst                 : clock, async active-high reset
//   stall                    : hold the IF/ID register
//   flush, flush_pc          : redirect fetch, clear IF/ID (highest priority)
//   branch_flag, branch_addr : taken branch in ID and its target
//   rom_en, rom_addr         : ROM request, held stable until rom_ready
//   rom_rdata, rom_ready     : ROM data and one-cycle completion pulse
//   stall_req                : fetch not yet complete
//   pc, inst, inst_valid     : IF/ID register contents seen by ID
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IF_FETCH | request at fetch_pc outstanding, waiting for rom_ready
// IF_HOLD  | word fetched during a stall, parked in hold_buf until release
// IF_DRAIN | request abandoned by a flush; wait for its rom_ready, drop data
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_rdata,
  input  logic              rom_ready,
  output logic              stall_req,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid
);

  if_state_e         state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic [INST_W-1:0] hold_buf, hold_buf_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [INST_W-1:0] inst_nxt;
  logic              inst_valid_nxt;
  logic [ADDR_W-1:0] next_pc;
  logic              in_reset;

  if_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .fetch_pc    (fetch_pc),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .next_pc     (next_pc)
  );

  assign in_reset = (rst == RST_ENABLE);

  // In DRAIN the ROM must keep seeing the abandoned address even though
  // fetch_pc already points at the flush target.
  assign rom_addr  = (state == IF_DRAIN) ? req_addr : fetch_pc;
  assign rom_en    = !in_reset && (state == IF_FETCH || state == IF_DRAIN);
  assign stall_req = !in_reset &&
                     ((state == IF_FETCH && !rom_ready) || state == IF_DRAIN);

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    hold_buf_nxt   = hold_buf;
    pc_nxt         = pc;
    inst_nxt       = inst;
    inst_valid_nxt = inst_valid;
    if (flush) begin
      fetch_pc_nxt   = flush_pc;
      pc_nxt         = ADDR_W'(ZERO_WORD);
      inst_nxt       = INST_W'(NOP_INST);
      inst_valid_nxt = 1'b0;
      // A request still in flight must be allowed to complete before the
      // redirected fetch is issued.
      if ((state == IF_FETCH || state == IF_DRAIN) && !rom_ready) begin
        state_nxt = IF_DRAIN;
      end else begin
        state_nxt = IF_FETCH;
      end
    end else begin
      case (state)
        IF_FETCH: begin
          if (rom_ready) begin
            if (stall) begin
              hold_buf_nxt = rom_rdata;
              state_nxt    = IF_HOLD;
            end else begin
              pc_nxt         = fetch_pc;
              inst_nxt       = rom_rdata;
              inst_valid_nxt = 1'b1;
              fetch_pc_nxt   = next_pc;
            end
          end
        end
        IF_HOLD: begin
          if (!stall) begin
            pc_nxt         = fetch_pc;
            inst_nxt       = hold_buf;
            inst_valid_nxt = 1'b1;
            fetch_pc_nxt   = next_pc;
            state_nxt      = IF_FETCH;
          end
        end
        IF_DRAIN: begin
          if (rom_ready) begin
            state_nxt = IF_FETCH;
          end
        end
        default: state_nxt = IF_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= IF_FETCH;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_buf   <= INST_W'(ZERO_WORD);
      pc         <= ADDR_W'(ZERO_WORD);
      inst       <= INST_W'(NOP_INST);
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      hold_buf   <= hold_buf_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_valid <= inst_valid_nxt;
      // Only FETCH can start a request, so tracking fetch_pc there keeps
      // the in-flight address available for DRAIN.
      if (state == IF_FETCH) begin
        req_addr <= fetch_pc;
      end
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID decoders.
- Owns the fetch PC and drives the instruction ROM through a request/ready handshake. Presents pc/inst to ID and consumes ID's branch_flag/branch_addr, honouring one MIPS delay slot.
- Handles pipeline stall, exception flush and multi-cycle ROM latency. Requests a stall while a fetch is outstanding.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- ADDR_W, 32, address/PC width (`ADDR_BUS`).
- INST_W, 32, instruction width (`INST_BUS`).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high (`RST_ENABLE` = 1).
- stall  in  1  from pipeline control; hold the IF/ID register.
- flush  in  1  exception/eret redirect; highest priority.
- flush_pc  in  ADDR_W  redirect target, valid with flush.
- branch_flag  in  1  from ID; instruction held in ID is a taken jump/branch.
- branch_addr  in  ADDR_W  from ID; target.
- rom_en  out  1  fetch request.
- rom_addr  out  ADDR_W  fetch address.
- rom_rdata  in  INST_W  instruction, valid with rom_ready.
- rom_ready  in  1  one-cycle completion pulse.
- stall_req  out  1  to pipeline control; fetch not yet complete.
- pc  out  ADDR_W  PC of the instruction in ID.
- inst  out  INST_W  instruction in ID (0 = nop).
- inst_valid  out  1  inst is a real fetched instruction.

Behaviour:
- Registers: fetch_pc, state, hold_buf (INST_W), pc, inst, inst_valid.
- Async reset values: fetch_pc = RESET_PC, state = FETCH, pc = 0, inst = 0, inst_valid = 0, hold_buf = 0.
- Combinational outputs are forced to 0 while rst is high: rom_en = 0, stall_req = 0.
- ROM protocol: rom_en and rom_addr stay stable from first assertion until the rom_ready cycle. rom_ready arrives 1..N cycles after the request starts. Only one request is outstanding at a time.
- next_pc = branch_flag ? branch_addr : fetch_pc + 4. It is evaluated at the cycle the fetched word is transferred into pc/inst. At that cycle ID still holds the branch, so the transferred word is the delay slot and the following fetch is the target.
- rom_en = (state == FETCH) or (state == DRAIN). rom_addr = fetch_pc.
- stall_req = (state == FETCH && !rom_ready) or (state == DRAIN).
- FETCH state:
  - rom_ready && !stall: pc <= fetch_pc, inst <= rom_rdata, inst_valid <= 1, fetch_pc <= next_pc; stay in FETCH. Back-to-back fetches give throughput of one instruction per cycle with a 1-cycle ROM.
  - rom_ready && stall: hold_buf <= rom_rdata; go to HOLD. pc/inst are unchanged.
  - !rom_ready: keep requesting. pc/inst/inst_valid are unchanged.
- HOLD state (rom_en = 0):
  - While stall: hold.
  - On !stall: pc <= fetch_pc, inst <= hold_buf, inst_valid <= 1, fetch_pc <= next_pc; go to FETCH.
- DRAIN state (rom_en = 1, address unchanged):
  - Waits for rom_ready to complete an abandoned request.
  - On rom_ready: discard data; go to FETCH. fetch_pc already holds flush_pc.
- flush, any state, overrides stall and branch_flag:
  - fetch_pc <= flush_pc, inst <= 0, pc <= 0, inst_valid <= 0.
  - Next state is DRAIN if state == FETCH && !rom_ready (request in flight); otherwise FETCH.
  - In DRAIN, rom_addr must still show the old address. A shadow register req_addr holds the in-flight address, and rom_addr = req_addr in DRAIN.
  - A flush while in DRAIN updates fetch_pc and stays in DRAIN.
- fetch_pc + 4 wraps modulo 2^ADDR_W. No alignment check is done in this block.
- Reset asserted mid-transaction: the block returns to the reset state asynchronously. The ROM controller is reset by the same rst.

Decomposition:
- Shared package/defines: RESET_PC value, IF state encodings (FETCH/HOLD/DRAIN), NOP_INST = 0; reuse `ADDR_BUS`, `INST_BUS`, `ZERO_WORD`, `RST_ENABLE`.
- One natural sub-module: if_pc_next (combinational next_pc mux + incrementer). Everything else stays in if_fetch.

Test Plan:
- Reset release, 1-cycle ROM, no stall -> rom_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; pc follows one cycle later; inst_valid = 1 from the first completion.
- 3-cycle ROM latency at 0xBFC00000 -> stall_req high for 2 cycles, low on the ready cycle; pc = 0xBFC00000, inst = rom_rdata the next cycle.
- ID holds a jump (branch_flag = 1, branch_addr = 0x80001000) while 0xBFC00008 is fetched -> the delay slot at 0xBFC00008 enters ID, then rom_addr = 0x80001000.
- stall = 1 across the rom_ready of 0xBFC00004 (data 0x24020005), stall released 2 cycles later -> state HOLD, rom_en = 0 while stalled; inst = 0x24020005 the cycle after release; the next request is 0xBFC00008.
- flush (flush_pc = 0xBFC00380) while the 0xBFC00010 request is outstanding, ready 2 cycles later -> inst = 0 and inst_valid = 0 immediately; rom_addr stays 0xBFC00010 until ready; that data is discarded; the next request is 0xBFC00380.
- Async rst pulse mid-HOLD -> all outputs return to reset values without a clock edge; fetch restarts at 0xBFC00000.
